// File: rtl/pnl_bram_block_mover.sv
// PNL BRAM block mover: copy, fill, reverse copy and copy-with-add over a
// contiguous block, sharing the single BRAM port.
module pnl_bram_block_mover #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              ready,
  output logic              done,
  input  logic [1:0]        mode,
  input  logic [ADDR_W:0]   num_vals,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] tgt_addr,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [ADDR_W:0]   elem_count
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WAIT_W = 3;

  localparam logic [1:0] MODE_FILL = 2'd1;
  localparam logic [1:0] MODE_REV  = 2'd2;
  localparam logic [1:0] MODE_ADD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t              state;
  logic [1:0]          mode_r;
  logic [CNT_W-1:0]    num_r;
  logic [ADDR_W-1:0]   src_r;
  logic [ADDR_W-1:0]   tgt_r;
  logic [DATA_W-1:0]   op_r;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                we_r;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                last_elem;

  // Element offset: ascending, or descending for the overlap-safe reverse copy.
  function automatic logic [ADDR_W-1:0] off_of(input logic [1:0] m,
                                               input logic [CNT_W-1:0] n,
                                               input logic [CNT_W-1:0] i);
    logic [ADDR_W-1:0] o;
    if (m == MODE_REV) o = ADDR_W'(n - CNT_W'(1) - i);
    else               o = ADDR_W'(i);
    return o;
  endfunction

  always_comb begin
    cnt_nxt   = elem_count + CNT_W'(1);
    last_elem = (cnt_nxt == num_r);
  end

  // Abort suppresses the write of the cycle it is seen in.
  assign bram_we = we_r & ~abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      we_r       <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      elem_count <= '0;
      mode_r     <= '0;
      num_r      <= '0;
      src_r      <= '0;
      tgt_r      <= '0;
      op_r       <= '0;
      wait_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          we_r      <= 1'b0;
          bram_addr <= '0;
          bram_din  <= '0;
          ready     <= 1'b1;
          if (start) begin
            mode_r     <= mode;
            num_r      <= num_vals;
            src_r      <= src_addr;
            tgt_r      <= tgt_addr;
            op_r       <= operand;
            elem_count <= '0;
            ready      <= 1'b0;
            if (num_vals == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (mode == MODE_FILL) begin
              state     <= S_FILL;
              we_r      <= 1'b1;
              bram_addr <= tgt_addr;
              bram_din  <= operand;
            end else begin
              state     <= S_RD_ISSUE;
              bram_addr <= src_addr + off_of(mode, num_vals, '0);
            end
          end
        end
        S_RD_ISSUE: begin
          state    <= S_RD_WAIT;
          wait_cnt <= '0;
        end
        S_RD_WAIT: begin
          if (wait_cnt == WAIT_W'(RD_LAT - 1)) begin
            state     <= S_WR;
            we_r      <= 1'b1;
            bram_addr <= tgt_r + off_of(mode_r, num_r, elem_count);
            bram_din  <= (mode_r == MODE_ADD) ? bram_dout + op_r : bram_dout;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WR: begin
          we_r       <= 1'b0;
          elem_count <= cnt_nxt;
          if (last_elem) begin
            state     <= S_DONE;
            done      <= 1'b1;
            bram_addr <= '0;
            bram_din  <= '0;
          end else begin
            state     <= S_RD_ISSUE;
            bram_addr <= src_r + off_of(mode_r, num_r, cnt_nxt);
          end
        end
        S_FILL: begin
          elem_count <= cnt_nxt;
          if (last_elem) begin
            state     <= S_DONE;
            done      <= 1'b1;
            we_r      <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
          end else begin
            bram_addr <= tgt_r + off_of(mode_r, num_r, cnt_nxt);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
          we_r  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Abort wins over every transition; completed writes stay counted.
      if (abort && (state != S_IDLE)) begin
        state      <= S_IDLE;
        ready      <= 1'b1;
        done       <= 1'b0;
        we_r       <= 1'b0;
        bram_addr  <= '0;
        bram_din   <= '0;
        elem_count <= elem_count;
      end
    end
  end

endmodule

// File: tb/tb_pnl_bram_block_mover.sv
// Scoreboard bench for pnl_bram_block_mover with a behavioural BRAM (RD_LAT=2).
module tb_pnl_bram_block_mover;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              ready;
  logic              done;
  logic [1:0]        mode = '0;
  logic [ADDR_W:0]   num_vals = '0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] tgt_addr = '0;
  logic [DATA_W-1:0] operand = '0;
  logic [DATA_W-1:0] bram_dout;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [ADDR_W:0]   elem_count;

  pnl_bram_block_mover #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .ready(ready),
    .done(done), .mode(mode), .num_vals(num_vals), .src_addr(src_addr),
    .tgt_addr(tgt_addr), .operand(operand), .bram_dout(bram_dout),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: read-before-write, read data delayed RD_LAT edges.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bram_addr];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (bram_we) mem[bram_addr] <= bram_din;
  end
  assign bram_dout = rd_pipe[RD_LAT-1];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                gap;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_wr_cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issued write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset_n && bram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", bram_addr, bram_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bram_addr), 32'(e.addr));
        chk("wr_data", 32'(bram_din), 32'(e.data));
        if (e.gap != 0) chk("wr_gap", 32'(cyc - last_wr_cyc), 32'(e.gap));
      end
      last_wr_cyc = cyc;
    end
    if (reset_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int gap);
    wr_t e;
    e.addr = a; e.data = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; waits for ready, pulses start, then scrambles inputs.
  task automatic start_xfer(input logic [1:0] m, input int n, input logic [ADDR_W-1:0] s,
                            input logic [ADDR_W-1:0] t, input logic [DATA_W-1:0] op);
    int guard = 0;
    while (!ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!ready) chk("ready_before_start", 32'(ready), 32'd1);
    mode = m; num_vals = (ADDR_W+1)'(n); src_addr = s; tgt_addr = t; operand = op;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'(~m); num_vals = '1; src_addr = ~s; tgt_addr = ~t; operand = ~op;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int guard = 0;
    while (done_cnt == d0 && guard < 200) begin
      @(negedge clk); guard++;
    end
    if (done_cnt == d0) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    chk({name, "_ready_after_done"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int d0;
    int nw;
    mem[14'h100] = 16'd1; mem[14'h101] = 16'd2; mem[14'h102] = 16'd3;
    mem[14'h020] = 16'hA; mem[14'h021] = 16'hB; mem[14'h022] = 16'hC; mem[14'h023] = 16'hD;
    mem[14'h3FFF] = 16'hFFFF; mem[14'h000] = 16'h1234;
    for (int k = 0; k < 5; k++) mem[14'h400 + k] = 16'(16'h40 + k);
    mem[14'h501] = 16'h0; mem[14'h700] = 16'h0;

    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_din", 32'(bram_din), 32'd0);
    chk("rst_count", 32'(elem_count), 32'd0);
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;

    // Fill: four back-to-back writes, done the cycle after the last one
    for (int k = 0; k < 4; k++) push(14'(14'h10 + k), 16'hABCD, (k == 0) ? 0 : 1);
    start_xfer(2'd1, 4, 14'h0, 14'h10, 16'hABCD);
    wait_done("fill");
    chk("fill_done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
    chk("fill_count", 32'(elem_count), 32'd4);

    // Forward copy: RD_LAT+2 = 4 cycles per element
    push(14'h200, 16'd1, 0); push(14'h201, 16'd2, 4); push(14'h202, 16'd3, 4);
    d0 = done_cnt;
    start_xfer(2'd0, 3, 14'h100, 14'h200, 16'h0);
    wait_done("copy");
    repeat (3) @(posedge clk); #1;
    chk("copy_done_once", 32'(done_cnt - d0), 32'd1);
    chk("copy_count", 32'(elem_count), 32'd3);

    // Overlapping reverse copy
    push(14'h25, 16'hD, 0); push(14'h24, 16'hC, 4); push(14'h23, 16'hB, 4); push(14'h22, 16'hA, 4);
    start_xfer(2'd2, 4, 14'h20, 14'h22, 16'h0);
    wait_done("rev");
    chk("rev_m20", 32'(mem[14'h20]), 32'hA);
    chk("rev_m21", 32'(mem[14'h21]), 32'hB);
    chk("rev_m22", 32'(mem[14'h22]), 32'hA);
    chk("rev_m23", 32'(mem[14'h23]), 32'hB);
    chk("rev_m24", 32'(mem[14'h24]), 32'hC);
    chk("rev_m25", 32'(mem[14'h25]), 32'hD);

    // Copy+add with source address and data wrap
    push(14'h300, 16'h0001, 0); push(14'h301, 16'h1236, 4);
    start_xfer(2'd3, 2, 14'h3FFF, 14'h300, 16'h0002);
    wait_done("add");
    chk("add_count", 32'(elem_count), 32'd2);

    // Zero count: done in the cycle after acceptance, no BRAM write
    start_xfer(2'd0, 0, 14'h100, 14'h800, 16'h0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_count", 32'(elem_count), 32'd0);
    @(posedge clk); #1;
    chk("zero_ready", 32'(ready), 32'd1);

    // Abort during the second write of a 5-element copy
    push(14'h500, 16'h40, 0);
    d0 = done_cnt;
    nw = 0;
    start_xfer(2'd0, 5, 14'h400, 14'h500, 16'h0);
    for (int g = 0; g < 60; g++) begin
      if (bram_we) nw++;
      if (nw == 2) begin
        abort = 1'b1;
        #1;
        chk("abort_we_low", 32'(bram_we), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    chk("abort_reached", 32'(nw), 32'd2);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_count", 32'(elem_count), 32'd1);
    repeat (4) @(posedge clk); #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_m501", 32'(mem[14'h501]), 32'd0);
    push(14'h600, 16'h5A5A, 0); push(14'h601, 16'h5A5A, 1);
    start_xfer(2'd1, 2, 14'h0, 14'h600, 16'h5A5A);
    wait_done("post_abort");
    chk("post_abort_count", 32'(elem_count), 32'd2);

    // Reset asserted on the first write of a copy
    nw = 0;
    start_xfer(2'd0, 3, 14'h100, 14'h700, 16'h0);
    for (int g = 0; g < 60; g++) begin
      if (bram_we) begin
        nw = 1;
        reset_n = 1'b0;
        #1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rstmid_reached", 32'(nw), 32'd1);
    chk("rstmid_we", 32'(bram_we), 32'd0);
    chk("rstmid_ready", 32'(ready), 32'd1);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_addr", 32'(bram_addr), 32'd0);
    chk("rstmid_din", 32'(bram_din), 32'd0);
    chk("rstmid_count", 32'(elem_count), 32'd0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("rstmid_m700", 32'(mem[14'h700]), 32'd0);
    chk("rstmid_idle_ready", 32'(ready), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
